// File: rtl/cnn_mac_pkg.sv
// Shared widths, fixed-point constants and FSM encoding for the CNN MAC sequencer.
package cnn_mac_pkg;

   localparam int unsigned FEAT_W   = 14;
   localparam int unsigned WGT_W    = 7;
   localparam int unsigned WGT_FRAC = 6;
   localparam int unsigned PROD_W   = FEAT_W + WGT_W;
   localparam int unsigned MAX_LEN  = 256;
   localparam int unsigned ADDR_W   = $clog2(MAX_LEN);
   localparam int unsigned LEN_W    = ADDR_W + 1;
   localparam int unsigned ACC_W    = PROD_W + $clog2(MAX_LEN);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/cnn_mac_sat.sv
// Rescale a full-precision accumulator back to the feature format:
// floor shift by the weight fraction bits, then clamp to the feature range.
module cnn_mac_sat
   import cnn_mac_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [FEAT_W-1:0] result_c
);

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (FEAT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   logic signed [ACC_W-1:0] shifted;

   always_comb begin
      shifted = acc >>> WGT_FRAC;
      if (shifted > SAT_HI) begin
         result_c = SAT_HI[FEAT_W-1:0];
      end else if (shifted < SAT_LO) begin
         result_c = SAT_LO[FEAT_W-1:0];
      end else begin
         result_c = shifted[FEAT_W-1:0];
      end
   end

endmodule

// File: rtl/cnn_mac_seq.sv
// Dot-product sequencer: streams feature/weight buffers through an external
// multiplier, accumulates with bias, and returns a saturated feature value.
module cnn_mac_seq
   import cnn_mac_pkg::*;
(
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic [LEN_W-1:0]  len,
   input  logic [FEAT_W-1:0] bias,
   output logic [ADDR_W-1:0] feat_address0,
   output logic              feat_ce0,
   input  logic [FEAT_W-1:0] feat_q0,
   output logic [ADDR_W-1:0] wgt_address0,
   output logic              wgt_ce0,
   input  logic [WGT_W-1:0]  wgt_q0,
   output logic [FEAT_W-1:0] mul_din0,
   output logic [WGT_W-1:0]  mul_din1,
   input  logic [PROD_W-1:0] mul_dout,
   output logic [FEAT_W-1:0] ap_return
);

   state_t                   state;
   state_t                   next_state;
   logic [LEN_W-1:0]         len_q;
   logic [ADDR_W-1:0]        addr;
   logic                     ce;
   logic                     drain_cnt;
   logic                     v1;
   logic                     v2;
   logic [PROD_W-1:0]        prod_reg;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [FEAT_W-1:0] sat_c;
   logic                     start_c;
   logic                     last_c;

   assign start_c  = (state == IDLE) && ap_start;
   assign last_c   = (LEN_W'(addr) == (len_q - LEN_W'(1)));
   assign prod_ext = ACC_W'($signed(prod_reg));
   // Final product lands on the same edge that enters DONE, so saturate the next value.
   assign acc_next = v2 ? (acc + prod_ext) : acc;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (ap_start) next_state = (len == '0) ? DRAIN : RUN;
         RUN:     if (last_c) next_state = DRAIN;
         DRAIN:   if (drain_cnt) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         len_q     <= '0;
         addr      <= '0;
         ce        <= 1'b0;
         drain_cnt <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         prod_reg  <= '0;
         acc       <= '0;
         ap_done   <= 1'b0;
         ap_idle   <= 1'b1;
         ap_return <= '0;
      end else begin
         ce        <= (next_state == RUN);
         drain_cnt <= (state == DRAIN) && !drain_cnt;
         v1        <= ce;
         v2        <= v1;
         prod_reg  <= mul_dout;
         ap_done   <= (next_state == DONE);
         ap_idle   <= (next_state == IDLE);
         if (state == IDLE) begin
            addr <= '0;
         end else if ((state == RUN) && (next_state == RUN)) begin
            addr <= addr + ADDR_W'(1);
         end
         if (start_c) begin
            len_q <= len;
            acc   <= ACC_W'($signed(bias)) <<< WGT_FRAC;
         end else begin
            acc <= acc_next;
         end
         if (next_state == DONE) begin
            ap_return <= sat_c;
         end
      end
   end

   cnn_mac_sat u_sat (
      .acc      (acc_next),
      .result_c (sat_c)
   );

   assign feat_address0 = addr;
   assign wgt_address0  = addr;
   assign feat_ce0      = ce;
   assign wgt_ce0       = ce;
   assign mul_din0      = v1 ? feat_q0 : '0;
   assign mul_din1      = v1 ? wgt_q0 : '0;
   assign ap_ready      = ap_done;

endmodule
